// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream controller and its output buffer.
package ram_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DUMP,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 6;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned SKID_DEPTH     = 2;
  localparam int unsigned SKID_CNT_W     = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_stream_skid.sv
// Two-entry output buffer holding captured RAM read words for the dump stream.
module ram_stream_skid
  import ram_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] e0_q, e1_q;
  logic [SKID_CNT_W-1:0] cnt_q;
  logic                  do_pop, do_push;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != SKID_CNT_W'(SKID_DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == '0) e0_q <= push_data;
          else             e1_q <= push_data;
          cnt_q <= cnt_q + SKID_CNT_W'(1);
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - SKID_CNT_W'(1);
        end
        2'b11: begin
          // simultaneous push/pop keeps the count; the new word lands behind any survivor
          if (cnt_q == SKID_CNT_W'(1)) begin
            e0_q <= push_data;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt_q;
  assign head  = e0_q;

endmodule

// File: rtl/ram_stream_ctrl.sv
// Fill/dump controller between valid/ready streams and a single-port sync-read RAM.
// Optional RAM_STREAM_LAST_EN adds s_last (early fill end) and m_last (final dump word).
module ram_stream_ctrl
  import ram_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
`ifdef RAM_STREAM_LAST_EN
  input  logic                  s_last,
  output logic                  m_last,
`endif
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, remain_q;
  logic                  inflight_q;
  logic [SKID_CNT_W-1:0] fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  accept, s_fire, pop, issue, last_word, s_last_i;

`ifdef RAM_STREAM_LAST_EN
  assign s_last_i = s_last;
`else
  assign s_last_i = 1'b0;
`endif

  assign accept    = cmd_valid && cmd_ready;
  assign s_fire    = (state_q == FILL) && s_valid;
  assign m_valid   = (fifo_cnt != '0);
  assign m_data    = fifo_head;
  assign pop       = m_valid && m_ready;
  assign last_word = (remain_q == '0);
  // a read may issue only if its word is guaranteed a buffer slot when it returns
  assign issue     = (state_q == DUMP) &&
                     ((3'(fifo_cnt) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = cmd_write ? FILL : DUMP;
      FILL:    if (s_fire && (last_word || s_last_i)) state_d = DONE;
      DUMP:    if (issue && last_word) state_d = DRAIN;
      // leave on the cycle the final word hands off, so done follows it directly
      DRAIN:   if (!inflight_q && (fifo_cnt == SKID_CNT_W'(pop))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        busy      = 1'b0;
      end
      FILL: begin
        s_ready  = 1'b1;
        ram_we   = s_valid;
        ram_addr = addr_q;
        ram_din  = s_data;
      end
      DUMP:    ram_addr = addr_q;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q   <= cmd_base;
        remain_q <= cmd_len;
      end else if (s_fire || issue) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        remain_q <= remain_q - ADDR_WIDTH'(1);
      end
    end
  end

`ifdef RAM_STREAM_LAST_EN
  logic [ADDR_WIDTH-1:0] out_rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_rem_q <= '0;
    else if (accept) out_rem_q <= cmd_len;
    else if (pop)    out_rem_q <= out_rem_q - ADDR_WIDTH'(1);
  end

  assign m_last = m_valid && (out_rem_q == '0);
`endif

  ram_stream_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .push     (inflight_q),
    .push_data(ram_dout),
    .pop      (pop),
    .count    (fifo_cnt),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Directed bench for ram_stream_ctrl with a behavioural 64x32 read-before-write RAM.
module tb_ram_stream_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_base, cmd_len;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy, done;
`ifdef RAM_STREAM_LAST_EN
  logic          s_last, m_last;
`endif

  logic [DW-1:0] mem [0:63];
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  ram_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_base (cmd_base),
    .cmd_len  (cmd_len),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
`ifdef RAM_STREAM_LAST_EN
    .s_last   (s_last),
    .m_last   (m_last),
`endif
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy),
    .done     (done)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_base  = base;
    cmd_len   = len;
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready got %0b exp 0", s_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid got %0b exp 0", m_valid); end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL rst_m_data got %h exp 0", m_data); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rst_ram_we got %0b exp 0", ram_we); end
    vectors++; if (ram_addr !== '0) begin miscompares++; $display("FAIL rst_ram_addr got %h exp 0", ram_addr); end
    vectors++; if (ram_din !== '0) begin miscompares++; $display("FAIL rst_ram_din got %h exp 0", ram_din); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %0b exp 0", done); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready got %0b exp 1", cmd_ready); end
    next_cycle();
  endtask

  task automatic test_fill_wrap;
    logic [AW-1:0] ea;
    s_valid = 1'b1;
    s_data  = 32'hA0;
    issue_cmd(1'b1, 6'h3E, 6'd3);
    for (int i = 0; i < 4; i++) begin
      s_data = 32'hA0 + i;
      ea = 6'h3E + 6'(i);
      @(negedge clk);
      vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL fill_we[%0d] got %0b exp 1", i, ram_we); end
      vectors++; if (ram_addr !== ea) begin miscompares++; $display("FAIL fill_addr[%0d] got %h exp %h", i, ram_addr, ea); end
      vectors++; if (ram_din !== 32'hA0 + i) begin miscompares++; $display("FAIL fill_din[%0d] got %h exp %h", i, ram_din, 32'hA0 + i); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL fill_early_done[%0d] got %0b exp 0", i, done); end
      next_cycle();
    end
    s_valid = 1'b0;
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL fill_done got %0b exp 1", done); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL fill_done_we got %0b exp 0", ram_we); end
    next_cycle();
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL fill_done_pulse got %0b exp 0", done); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL fill_cmd_ready got %0b exp 1", cmd_ready); end
  endtask

  task automatic test_dump_range;
    m_ready = 1'b1;
    issue_cmd(1'b0, 6'h3E, 6'd3);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vectors++; if (m_valid !== (c >= 3 && c <= 6)) begin miscompares++; $display("FAIL dump_m_valid[c%0d] got %0b exp %0b", c, m_valid, (c >= 3 && c <= 6)); end
      if (c >= 3 && c <= 6) begin
        vectors++; if (m_data !== 32'hA0 + (c - 3)) begin miscompares++; $display("FAIL dump_m_data[c%0d] got %h exp %h", c, m_data, 32'hA0 + (c - 3)); end
      end
      vectors++; if (done !== (c == 7)) begin miscompares++; $display("FAIL dump_done[c%0d] got %0b exp %0b", c, done, (c == 7)); end
      vectors++; if (cmd_ready !== (c == 8)) begin miscompares++; $display("FAIL dump_cmd_ready[c%0d] got %0b exp %0b", c, cmd_ready, (c == 8)); end
      next_cycle();
    end
  endtask

  task automatic test_dump_full;
    logic [7:0] lf;
    int got, cycles;
    logic done_seen;
    s_valid = 1'b1;
    s_data  = 32'h1000;
    issue_cmd(1'b1, 6'd0, 6'd63);
    for (int i = 0; i < 64; i++) begin
      s_data = 32'h1000 + i;
      @(negedge clk);
      vectors++; if (ram_addr !== 6'(i) || ram_we !== 1'b1) begin miscompares++; $display("FAIL full_fill_addr[%0d] got %h/%0b exp %h/1", i, ram_addr, ram_we, 6'(i)); end
      next_cycle();
    end
    s_valid = 1'b0;
    next_cycle();
    lf = 8'hA5;
    m_ready = 1'b1;
    issue_cmd(1'b0, 6'd0, 6'd63);
    got = 0;
    cycles = 0;
    done_seen = 1'b0;
    while (!done_seen && cycles < 2000) begin
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      m_ready = lf[0];
      @(negedge clk);
      if (m_valid && m_ready) begin
        vectors++; if (m_data !== 32'h1000 + got) begin miscompares++; $display("FAIL full_dump_word[%0d] got %h exp %h", got, m_data, 32'h1000 + got); end
        got++;
      end
      if (done) done_seen = 1'b1;
      next_cycle();
      cycles++;
    end
    vectors++; if (done_seen !== 1'b1) begin miscompares++; $display("FAIL full_dump_timeout got %0b exp 1", done_seen); end
    vectors++; if (got != 64) begin miscompares++; $display("FAIL full_dump_count got %0d exp 64", got); end
    m_ready = 1'b1;
  endtask

  task automatic test_reset_mid_fill;
    s_valid = 1'b1;
    s_data  = 32'h5500;
    issue_cmd(1'b1, 6'h10, 6'd3);
    next_cycle();
    s_data = 32'h5501;
    next_cycle();
    s_data = 32'h5502;
    rst = 1'b1;
    #1;
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL midrst_we got %0b exp 0", ram_we); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %0b exp 0", busy); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_s_ready got %0b exp 0", s_ready); end
    vectors++; if (ram_addr !== '0 || ram_din !== '0) begin miscompares++; $display("FAIL midrst_addr_din got %h/%h exp 0/0", ram_addr, ram_din); end
    vectors++; if (done !== 1'b0 || m_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_done_mvalid got %0b/%0b exp 0/0", done, m_valid); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL midrst_hold_we[%0d] got %0b exp 0", k, ram_we); end
      next_cycle();
    end
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    vectors++; if (mem[6'h10] !== 32'h5500) begin miscompares++; $display("FAIL midrst_mem10 got %h exp 5500", mem[6'h10]); end
    vectors++; if (mem[6'h11] !== 32'h5501) begin miscompares++; $display("FAIL midrst_mem11 got %h exp 5501", mem[6'h11]); end
    vectors++; if (mem[6'h12] !== 32'h1012) begin miscompares++; $display("FAIL midrst_mem12 got %h exp 1012", mem[6'h12]); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_cmd_ready got %0b exp 1", cmd_ready); end
    next_cycle();
  endtask

  task automatic test_cmd_hold;
    m_ready   = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_base  = 6'h20;
    cmd_len   = 6'd1;
    next_cycle();
    cmd_base = 6'h30;
    cmd_len  = 6'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL hold_cmd_ready[c%0d] got %0b exp 0", c, cmd_ready); end
      vectors++; if (m_valid !== (c == 3 || c == 4)) begin miscompares++; $display("FAIL hold_m_valid[c%0d] got %0b exp %0b", c, m_valid, (c == 3 || c == 4)); end
      if (c == 3 || c == 4) begin
        vectors++; if (m_data !== 32'h1020 + (c - 3)) begin miscompares++; $display("FAIL hold_m_data[c%0d] got %h exp %h", c, m_data, 32'h1020 + (c - 3)); end
      end
      vectors++; if (done !== (c == 5)) begin miscompares++; $display("FAIL hold_done[c%0d] got %0b exp %0b", c, done, (c == 5)); end
      next_cycle();
    end
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL hold_second_ready got %0b exp 1", cmd_ready); end
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vectors++; if (m_valid !== (c == 3)) begin miscompares++; $display("FAIL second_m_valid[c%0d] got %0b exp %0b", c, m_valid, (c == 3)); end
      if (c == 3) begin
        vectors++; if (m_data !== 32'h1030) begin miscompares++; $display("FAIL second_m_data got %h exp 1030", m_data); end
      end
      vectors++; if (done !== (c == 4)) begin miscompares++; $display("FAIL second_done[c%0d] got %0b exp %0b", c, done, (c == 4)); end
      next_cycle();
    end
  endtask

`ifdef RAM_STREAM_LAST_EN
  task automatic test_last;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 32'h7700;
    issue_cmd(1'b1, 6'h08, 6'd7);
    for (int c = 1; c <= 4; c++) begin
      s_data = 32'h7700 + (c - 1);
      s_last = (c == 3);
      @(negedge clk);
      vectors++; if (ram_we !== (c <= 3)) begin miscompares++; $display("FAIL last_fill_we[c%0d] got %0b exp %0b", c, ram_we, (c <= 3)); end
      vectors++; if (done !== (c == 4)) begin miscompares++; $display("FAIL last_fill_done[c%0d] got %0b exp %0b", c, done, (c == 4)); end
      next_cycle();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    vectors++; if (mem[6'h0A] !== 32'h7702 || mem[6'h0B] !== 32'h100B) begin miscompares++; $display("FAIL last_fill_mem got %h/%h exp 7702/100b", mem[6'h0A], mem[6'h0B]); end
    m_ready = 1'b1;
    issue_cmd(1'b0, 6'h08, 6'd2);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      vectors++; if (m_last !== (c == 5)) begin miscompares++; $display("FAIL last_m_last[c%0d] got %0b exp %0b", c, m_last, (c == 5)); end
      if (c == 5) begin
        vectors++; if (m_data !== 32'h7702) begin miscompares++; $display("FAIL last_m_data got %h exp 7702", m_data); end
      end
      next_cycle();
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 + i;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
`ifdef RAM_STREAM_LAST_EN
    s_last    = 1'b0;
`endif
    test_reset();
    test_fill_wrap();
    next_cycle();
    test_dump_range();
    test_dump_full();
    test_reset_mid_fill();
    test_cmd_hold();
`ifdef RAM_STREAM_LAST_EN
    test_last();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
